seven_seg_scanner: RTL

- Parametrised, time-multiplexed driver for a common-anode seven-segment display with N digits.
- Scans the digits, hex-decodes each digit's 4-bit value and drives the shared segment bus and the per-digit enables.
- New relative to the fixed 3-digit driver:
  - double-buffered values, swapped only at frame boundaries (tear-free);
  - per-digit decimal point and blanking;
  - PWM brightness;
  - anti-ghost guard cycle;
  - frame-done pulse.
- Sits between application logic and the board display pins.

---
 rtl/seven_seg_pkg.sv | 43 ++++
 rtl/seven_seg_scanner_if.sv | 24 ++
 rtl/hex_seg_decoder.sv | 32 +++
 rtl/seven_seg_scanner.sv | 138 +++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scanner: hex glyphs, bit positions, helpers.
package seven_seg_pkg;

    // Segment bit positions on the active-high segment bus.
    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Active-high gfedcba glyphs for hex digits 0..F.
    localparam logic [6:0] SEG_HEX_0 = 7'h3F;
    localparam logic [6:0] SEG_HEX_1 = 7'h06;
    localparam logic [6:0] SEG_HEX_2 = 7'h5B;
    localparam logic [6:0] SEG_HEX_3 = 7'h4F;
    localparam logic [6:0] SEG_HEX_4 = 7'h66;
    localparam logic [6:0] SEG_HEX_5 = 7'h6D;
    localparam logic [6:0] SEG_HEX_6 = 7'h7D;
    localparam logic [6:0] SEG_HEX_7 = 7'h07;
    localparam logic [6:0] SEG_HEX_8 = 7'h7F;
    localparam logic [6:0] SEG_HEX_9 = 7'h6F;
    localparam logic [6:0] SEG_HEX_A = 7'h77;
    localparam logic [6:0] SEG_HEX_B = 7'h7C;
    localparam logic [6:0] SEG_HEX_C = 7'h39;
    localparam logic [6:0] SEG_HEX_D = 7'h5E;
    localparam logic [6:0] SEG_HEX_E = 7'h79;
    localparam logic [6:0] SEG_HEX_F = 7'h71;

    // All eight segments (including dp) dark, active-high.
    localparam logic [7:0] SEG_OFF = 8'h00;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input longint unsigned v);
        int r;
        r = 0;
        while ((64'd1 << r) < v) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Application/pin-side bundle of the seven-segment scanner.
interface seven_seg_scanner_if #(
    parameter int DIGITS   = 3,
    parameter int BRIGHT_W = 4
);
    logic [4*DIGITS-1:0] Values;
    logic [DIGITS-1:0]   DpMask;
    logic [DIGITS-1:0]   BlankMask;
    logic                Load;
    logic [BRIGHT_W-1:0] Brightness;
    logic [7:0]          SevenSegment;
    logic [DIGITS-1:0]   Enable;
    logic                FrameDone;

    modport master (
        output Values, DpMask, BlankMask, Load, Brightness,
        input  SevenSegment, Enable, FrameDone
    );

    modport slave (
        input  Values, DpMask, BlankMask, Load, Brightness,
        output SevenSegment, Enable, FrameDone
    );
endinterface

// File: rtl/hex_seg_decoder.sv
// Combinational 4-bit hex to active-high gfedcba segment pattern.
module hex_seg_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Glyph lookup.
    always_comb begin
        seg = SEG_HEX_0;
        case (hex)
            4'h0: seg = SEG_HEX_0;
            4'h1: seg = SEG_HEX_1;
            4'h2: seg = SEG_HEX_2;
            4'h3: seg = SEG_HEX_3;
            4'h4: seg = SEG_HEX_4;
            4'h5: seg = SEG_HEX_5;
            4'h6: seg = SEG_HEX_6;
            4'h7: seg = SEG_HEX_7;
            4'h8: seg = SEG_HEX_8;
            4'h9: seg = SEG_HEX_9;
            4'hA: seg = SEG_HEX_A;
            4'hB: seg = SEG_HEX_B;
            4'hC: seg = SEG_HEX_C;
            4'hD: seg = SEG_HEX_D;
            4'hE: seg = SEG_HEX_E;
            default: seg = SEG_HEX_F;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode display driver: double-buffered digits,
// per-digit dp/blank, PWM brightness, guard cycle and frame-done pulse.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int DIGITS         = 3,
    parameter int DWELL          = 12000000,
    parameter int BRIGHT_W       = 4,
    parameter int ACTIVE_LOW_SEG = 1,
    parameter int ACTIVE_LOW_EN  = 1
) (
    input  logic               Clk,
    input  logic               RST,
    seven_seg_scanner_if.slave bus
);

    localparam int CNT_W = clog2(DWELL);
    localparam int IDX_W = (DIGITS > 1) ? clog2(DIGITS) : 1;
    localparam int ON_W  = CNT_W + BRIGHT_W + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(DWELL - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST     = IDX_W'(DIGITS - 1);
    localparam logic [7:0]        SEG_PINS_RST = (ACTIVE_LOW_SEG != 0) ? ~SEG_OFF : SEG_OFF;
    localparam logic [DIGITS-1:0] EN_PINS_RST  = (ACTIVE_LOW_EN != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    // Full brightness gives an on-time of exactly DWELL.
    localparam logic [ON_W-1:0]   ON_TIME_RST  = ON_W'(DWELL);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] pend_val_q, pend_val_d, act_val_q, act_val_d;
    logic [DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic [DIGITS-1:0]   pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
    logic [BRIGHT_W-1:0] pend_bright_q, pend_bright_d, act_bright_q, act_bright_d;
    logic [ON_W-1:0]     on_time_q, on_time_d, on_prod;
    logic [7:0]          seg_pins_q, seg_pins_d, seg_hi;
    logic [DIGITS-1:0]   en_pins_q, en_pins_d, en_hi;
    logic                frame_done_q, frame_done_d;
    logic                last_cnt, wrap, digit_on;
    logic [3:0]          cur_val;
    logic [6:0]          cur_seg;

    assign cur_val = act_val_q[{idx_q, 2'b00} +: 4];

    hex_seg_decoder u_dec (
        .hex (cur_val),
        .seg (cur_seg)
    );

    // Scan counters, pending/active buffers and per-frame on-time.
    always_comb begin
        last_cnt = (cnt_q == CNT_LAST);
        wrap     = last_cnt && (idx_q == IDX_LAST);
        cnt_d    = last_cnt ? '0 : cnt_q + CNT_W'(1);
        idx_d    = idx_q;
        if (last_cnt) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);

        pend_val_d    = pend_val_q;
        pend_dp_d     = pend_dp_q;
        pend_blank_d  = pend_blank_q;
        pend_bright_d = pend_bright_q;
        if (bus.Load) begin
            pend_val_d    = bus.Values;
            pend_dp_d     = bus.DpMask;
            pend_blank_d  = bus.BlankMask;
            pend_bright_d = bus.Brightness;
        end

        // Swapping from the next-pending value lets a wrap-cycle Load land directly.
        act_val_d    = act_val_q;
        act_dp_d     = act_dp_q;
        act_blank_d  = act_blank_q;
        act_bright_d = act_bright_q;
        if (wrap) begin
            act_val_d    = pend_val_d;
            act_dp_d     = pend_dp_d;
            act_blank_d  = pend_blank_d;
            act_bright_d = pend_bright_d;
        end

        // Full-width product so the shift never loses high bits.
        on_prod   = (ON_W'(act_bright_d) + ON_W'(1)) * ON_W'(DWELL);
        on_time_d = wrap ? (on_prod >> BRIGHT_W) : on_time_q;
    end

    // Digit select and segment bus for the current (index, cnt), polarity last.
    always_comb begin
        digit_on = (ON_W'(cnt_q) < on_time_q) && !last_cnt && !act_blank_q[idx_q];
        seg_hi   = SEG_OFF;
        en_hi    = '0;
        if (digit_on) begin
            seg_hi[SEG_G:SEG_A] = cur_seg;
            seg_hi[SEG_DP]      = act_dp_q[idx_q];
            en_hi[idx_q]        = 1'b1;
        end
        seg_pins_d   = (ACTIVE_LOW_SEG != 0) ? ~seg_hi : seg_hi;
        en_pins_d    = (ACTIVE_LOW_EN != 0) ? ~en_hi : en_hi;
        frame_done_d = wrap;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (RST) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            pend_val_q    <= '0;
            pend_dp_q     <= '0;
            pend_blank_q  <= '1;
            pend_bright_q <= '1;
            act_val_q     <= '0;
            act_dp_q      <= '0;
            act_blank_q   <= '1;
            act_bright_q  <= '1;
            on_time_q     <= ON_TIME_RST;
            seg_pins_q    <= SEG_PINS_RST;
            en_pins_q     <= EN_PINS_RST;
            frame_done_q  <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            pend_val_q    <= pend_val_d;
            pend_dp_q     <= pend_dp_d;
            pend_blank_q  <= pend_blank_d;
            pend_bright_q <= pend_bright_d;
            act_val_q     <= act_val_d;
            act_dp_q      <= act_dp_d;
            act_blank_q   <= act_blank_d;
            act_bright_q  <= act_bright_d;
            on_time_q     <= on_time_d;
            seg_pins_q    <= seg_pins_d;
            en_pins_q     <= en_pins_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign bus.SevenSegment = seg_pins_q;
    assign bus.Enable       = en_pins_q;
    assign bus.FrameDone    = frame_done_q;

endmodule
